// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_pkg
// Description : Shared constants for the multi-cycle RV controller: opcodes,
//               ALU operation encodings, instruction classes, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

    // Major opcodes
    localparam logic [6:0] c_opc_rtype = 7'b0110011;
    localparam logic [6:0] c_opc_itype = 7'b0010011;
    localparam logic [6:0] c_opc_load  = 7'b0000011;
    localparam logic [6:0] c_opc_store = 7'b0100011;

    // ALU operation encodings driven on alu_op
    localparam logic [4:0] c_alu_add  = 5'd0;
    localparam logic [4:0] c_alu_sub  = 5'd1;
    localparam logic [4:0] c_alu_slt  = 5'd2;
    localparam logic [4:0] c_alu_sltu = 5'd3;
    localparam logic [4:0] c_alu_and  = 5'd4;
    localparam logic [4:0] c_alu_or   = 5'd5;
    localparam logic [4:0] c_alu_xor  = 5'd6;
    localparam logic [4:0] c_alu_sll  = 5'd7;
    localparam logic [4:0] c_alu_srl  = 5'd8;
    localparam logic [4:0] c_alu_sra  = 5'd9;
    localparam logic [4:0] c_alu_mul  = 5'd10;
    localparam logic [4:0] c_alu_div  = 5'd12;
    localparam logic [4:0] c_alu_divu = 5'd13;
    localparam logic [4:0] c_alu_rem  = 5'd14;
    localparam logic [4:0] c_alu_remu = 5'd15;

    // Instruction classes
    typedef logic [1:0] instr_class_t;
    localparam instr_class_t c_cls_r     = 2'd0;
    localparam instr_class_t c_cls_i     = 2'd1;
    localparam instr_class_t c_cls_load  = 2'd2;
    localparam instr_class_t c_cls_store = 2'd3;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t c_st_fetch     = 3'd0;
    localparam state_t c_st_decode    = 3'd1;
    localparam state_t c_st_execute   = 3'd2;
    localparam state_t c_st_div_wait  = 3'd3;
    localparam state_t c_st_memory    = 3'd4;
    localparam state_t c_st_writeback = 3'd5;
    localparam state_t c_st_trap      = 3'd6;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Combinational decode of the instruction register into ALU
//               operation, class, sign-extended immediate, register fields
//               and an illegal-instruction flag.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
    import multicycle_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [4:0]      alu_op,
    output instr_class_t    instr_class,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            is_div,
    output logic            illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];

    // Opcode/funct decode with immediate sign extension to XLEN
    always_comb begin
        alu_op      = c_alu_add;
        instr_class = c_cls_r;
        imm         = '0;
        is_div      = 1'b0;
        illegal     = 1'b0;
        case (w_opcode)
            c_opc_rtype: begin
                instr_class = c_cls_r;
                case (w_funct7)
                    7'b0000000: begin
                        case (w_funct3)
                            3'b000:  alu_op = c_alu_add;
                            3'b001:  alu_op = c_alu_sll;
                            3'b010:  alu_op = c_alu_slt;
                            3'b011:  alu_op = c_alu_sltu;
                            3'b100:  alu_op = c_alu_xor;
                            3'b101:  alu_op = c_alu_srl;
                            3'b110:  alu_op = c_alu_or;
                            default: alu_op = c_alu_and;
                        endcase
                    end
                    7'b0100000: begin
                        if (w_funct3 == 3'b000) begin
                            alu_op = c_alu_sub;
                        end else if (w_funct3 == 3'b101) begin
                            alu_op = c_alu_sra;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    7'b0000001: begin
                        case (w_funct3)
                            3'b000: alu_op = c_alu_mul;
                            3'b100: begin alu_op = c_alu_div;  is_div = DIV_EN; illegal = !DIV_EN; end
                            3'b101: begin alu_op = c_alu_divu; is_div = DIV_EN; illegal = !DIV_EN; end
                            3'b110: begin alu_op = c_alu_rem;  is_div = DIV_EN; illegal = !DIV_EN; end
                            3'b111: begin alu_op = c_alu_remu; is_div = DIV_EN; illegal = !DIV_EN; end
                            default: illegal = 1'b1;   // MULH family not supported
                        endcase
                    end
                    default: illegal = 1'b1;
                endcase
            end
            c_opc_itype: begin
                instr_class = c_cls_i;
                imm         = {{(XLEN-12){instr[31]}}, instr[31:20]};
                case (w_funct3)
                    3'b000:  alu_op = c_alu_add;
                    3'b010:  alu_op = c_alu_slt;
                    3'b100:  alu_op = c_alu_xor;
                    3'b110:  alu_op = c_alu_or;
                    3'b111:  alu_op = c_alu_and;
                    default: illegal = 1'b1;
                endcase
            end
            c_opc_load: begin
                instr_class = c_cls_load;
                imm         = {{(XLEN-12){instr[31]}}, instr[31:20]};
                illegal     = (w_funct3 != 3'b010);
            end
            c_opc_store: begin
                instr_class = c_cls_store;
                imm         = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
                illegal     = (w_funct3 != 3'b010);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle RV32/64 instruction controller sequencing fetch,
//               decode, execute, divide wait, memory access and writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            fetch_req,
    input  logic            fetch_ack,
    input  logic [31:0]     instr,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic [4:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            start_div,
    input  logic            div_ready,
    output logic            mem_req,
    output logic            mem_write_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            reg_write_en,
    output logic [XLEN-1:0] wb_data,
    output logic            pc_inc,
    output logic            illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("multicycle_ctrl: XLEN must be 32 or 64");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_opa;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_res;
    logic [XLEN-1:0] r_store_data;

    logic [4:0]      w_dec_alu_op;
    instr_class_t    w_dec_class;
    logic [XLEN-1:0] w_dec_imm;
    logic [4:0]      w_dec_rs1;
    logic [4:0]      w_dec_rs2;
    logic [4:0]      w_dec_rd;
    logic            w_dec_is_div;
    logic            w_dec_illegal;
    logic            w_is_mem;

    instr_decoder #(
        .XLEN   (XLEN),
        .DIV_EN (DIV_EN)
    ) u_instr_decoder (
        .instr       (r_ir),
        .alu_op      (w_dec_alu_op),
        .instr_class (w_dec_class),
        .imm         (w_dec_imm),
        .rs1         (w_dec_rs1),
        .rs2         (w_dec_rs2),
        .rd          (w_dec_rd),
        .is_div      (w_dec_is_div),
        .illegal     (w_dec_illegal)
    );

    assign w_is_mem = (w_dec_class == c_cls_load) || (w_dec_class == c_cls_store);

    // State register; reset abandons any outstanding divide or memory access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: IR, operands, store data and result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir         <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_res        <= '0;
            r_store_data <= '0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (fetch_ack) r_ir <= instr;
                end
                c_st_decode: begin
                    r_opa        <= rdata1;
                    r_opb        <= (w_dec_class == c_cls_r) ? rdata2 : w_dec_imm;
                    r_store_data <= rdata2;
                end
                c_st_execute: begin
                    if (!w_dec_is_div) r_res <= alu_result;
                end
                c_st_div_wait: begin
                    if (div_ready) r_res <= alu_result;
                end
                c_st_memory: begin
                    if (mem_ready && (w_dec_class == c_cls_load)) r_res <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Next-state and outputs; reset forces every output low combinationally
    always_comb begin
        w_state_nxt  = r_state;
        fetch_req    = 1'b0;
        rs1          = '0;
        rs2          = '0;
        rd           = '0;
        alu_op       = '0;
        alu_a        = '0;
        alu_b        = '0;
        start_div    = 1'b0;
        mem_req      = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        reg_write_en = 1'b0;
        wb_data      = '0;
        pc_inc       = 1'b0;
        illegal      = 1'b0;
        if (!reset) begin
            case (r_state)
                c_st_fetch: begin
                    fetch_req = 1'b1;
                    if (fetch_ack) w_state_nxt = c_st_decode;
                end
                c_st_decode: begin
                    rs1         = w_dec_rs1;
                    rs2         = w_dec_rs2;
                    w_state_nxt = w_dec_illegal ? c_st_trap : c_st_execute;
                end
                c_st_execute: begin
                    alu_op = w_dec_alu_op;
                    alu_a  = r_opa;
                    alu_b  = r_opb;
                    if (w_dec_is_div) begin
                        start_div   = 1'b1;
                        w_state_nxt = c_st_div_wait;
                    end else if (w_is_mem) begin
                        w_state_nxt = c_st_memory;
                    end else begin
                        w_state_nxt = c_st_writeback;
                    end
                end
                c_st_div_wait: begin
                    alu_op = w_dec_alu_op;
                    alu_a  = r_opa;
                    alu_b  = r_opb;
                    if (div_ready) w_state_nxt = c_st_writeback;
                end
                c_st_memory: begin
                    mem_req  = 1'b1;
                    mem_addr = r_res;
                    if (w_dec_class == c_cls_store) begin
                        mem_write_en = 1'b1;
                        mem_wdata    = r_store_data;
                    end
                    if (mem_ready) begin
                        if (w_dec_class == c_cls_store) begin
                            pc_inc      = 1'b1;
                            w_state_nxt = c_st_fetch;
                        end else begin
                            w_state_nxt = c_st_writeback;
                        end
                    end
                end
                c_st_writeback: begin
                    rd           = w_dec_rd;
                    wb_data      = r_res;
                    reg_write_en = (w_dec_rd != 5'd0);
                    pc_inc       = 1'b1;
                    w_state_nxt  = c_st_fetch;
                end
                c_st_trap: begin
                    illegal = 1'b1;
                end
                default: w_state_nxt = c_st_fetch;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl (XLEN=64): table of
//               ALU instructions plus divide, store, load, trap and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            fetch_req, fetch_ack;
    logic [31:0]     instr;
    logic [4:0]      rs1, rs2, rd, alu_op;
    logic [XLEN-1:0] rdata1, rdata2, alu_a, alu_b, alu_result;
    logic            start_div, div_ready;
    logic            mem_req, mem_write_en, mem_ready;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata, wb_data;
    logic            reg_write_en, pc_inc, illegal;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.XLEN(XLEN), .DIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack), .instr(instr),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .rdata1(rdata1), .rdata2(rdata2),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .start_div(start_div), .div_ready(div_ready),
        .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .reg_write_en(reg_write_en), .wb_data(wb_data),
        .pc_inc(pc_inc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] res;
        logic [4:0]  op;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        wen;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{fetch_req, rs1, rs2, rd, alu_op, alu_a, alu_b, start_div, mem_req,
                 mem_write_en, mem_addr, mem_wdata, reg_write_en, wb_data, pc_inc, illegal};
    endfunction

    // Wait (bounded) for fetch_req, hand over an instruction, return in DECODE
    task automatic fetch(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
        int n = 0;
        while (fetch_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_wait", {63'd0, fetch_req}, 64'd1);
        instr     = ins;
        rdata1    = r1;
        rdata2    = r2;
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        instr     = '0;
    endtask

    task automatic run_vec(input vec_t v);
        fetch(v.ins, v.r1, v.r2);
        chk("decode_no_fetch", {63'd0, fetch_req}, 64'd0);
        @(negedge clk);
        chk("exec_alu_op", {59'd0, alu_op}, {59'd0, v.op});
        chk("exec_alu_a", alu_a, v.r1);
        chk("exec_alu_b", alu_b, v.b);
        alu_result = v.res;
        @(negedge clk);
        alu_result = '0;
        chk("wb_reg_write_en", {63'd0, reg_write_en}, {63'd0, v.wen});
        chk("wb_rd", {59'd0, rd}, {59'd0, v.rd});
        chk("wb_data", wb_data, v.res);
        chk("wb_pc_inc", {63'd0, pc_inc}, 64'd1);
        @(negedge clk);
        chk("wb_pulse_one_cycle", {62'd0, reg_write_en, pc_inc}, 64'd0);
    endtask

    initial begin
        //          instr          rdata1                 rdata2   result                 op     alu_b                  rd     wen
        vecs[0]  = '{32'hFFD00293, 64'd0,                 64'h55,  64'hFFFF_FFFF_FFFF_FFFD, 5'd0,  64'hFFFF_FFFF_FFFF_FFFD, 5'd5,  1'b1}; // ADDI x5,x0,-3
        vecs[1]  = '{32'h002081B3, 64'd10,                64'd20,  64'd30,                 5'd0,  64'd20,                5'd3,  1'b1}; // ADD
        vecs[2]  = '{32'h40208233, 64'd10,                64'd20,  64'hFFFF_FFFF_FFFF_FFF6, 5'd1,  64'd20,                5'd4,  1'b1}; // SUB
        vecs[3]  = '{32'h4020D333, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 5'd9,  64'd2,                 5'd6,  1'b1}; // SRA
        vecs[4]  = '{32'h0020B3B3, 64'd10,                64'd20,  64'd1,                  5'd3,  64'd20,                5'd7,  1'b1}; // SLTU
        vecs[5]  = '{32'h02208433, 64'd10,                64'd20,  64'd200,                5'd10, 64'd20,                5'd8,  1'b1}; // MUL
        vecs[6]  = '{32'h7FF0C493, 64'h0F0,               64'h55,  64'h70F,                5'd6,  64'h7FF,               5'd9,  1'b1}; // XORI 0x7FF
        vecs[7]  = '{32'hFFF0A513, 64'd5,                 64'h55,  64'd0,                  5'd2,  64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 1'b1}; // SLTI -1
        vecs[8]  = '{32'h00208033, 64'd1,                 64'd2,   64'd3,                  5'd0,  64'd2,                 5'd0,  1'b0}; // ADD x0
        vecs[9]  = '{32'h8000F593, 64'hFFFF,              64'h55,  64'hF800,               5'd4,  64'hFFFF_FFFF_FFFF_F800, 5'd11, 1'b1}; // ANDI -2048
        vecs[10] = '{32'h00209633, 64'd1,                 64'd4,   64'd16,                 5'd7,  64'd4,                 5'd12, 1'b1}; // SLL
        vecs[11] = '{32'h0020E6B3, 64'hF0,                64'h0F,  64'hFF,                 5'd5,  64'h0F,                5'd13, 1'b1}; // OR

        fetch_ack = 0; instr = 0; rdata1 = 0; rdata2 = 0; alu_result = 0;
        div_ready = 0; mem_rdata = 0; mem_ready = 0;

        // Reset state
        #1;
        chk("reset_outputs_zero", {63'd0, any_out()}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_fetch_req", {63'd0, fetch_req}, 64'd1);
        chk("post_reset_illegal", {63'd0, illegal}, 64'd0);

        // Table-driven ALU instructions
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // DIV x14,x1,x2 with div_ready arriving in the 10th wait cycle
        fetch(32'h0220C733, 64'd100, 64'd7);
        @(negedge clk);
        chk("div_start", {63'd0, start_div}, 64'd1);
        chk("div_exec_op", {59'd0, alu_op}, 64'd12);
        alu_result = 64'hDEAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("div_start_once", {63'd0, start_div}, 64'd0);
            chk("div_wait_op", {59'd0, alu_op}, 64'd12);
            chk("div_wait_a", alu_a, 64'd100);
            chk("div_wait_b", alu_b, 64'd7);
            chk("div_wait_no_wb", {63'd0, reg_write_en}, 64'd0);
            if (i == 9) begin
                div_ready  = 1'b1;
                alu_result = 64'd14;
            end
        end
        @(negedge clk);
        div_ready  = 1'b0;
        alu_result = '0;
        chk("div_wb_en", {63'd0, reg_write_en}, 64'd1);
        chk("div_wb_rd", {59'd0, rd}, 64'd14);
        chk("div_wb_data", wb_data, 64'd14);
        @(negedge clk);

        // SW x2,8(x1) with mem_ready in the 4th memory cycle
        fetch(32'h0020A423, 64'h1000, 64'hCAFE);
        @(negedge clk);
        chk("sw_exec_op", {59'd0, alu_op}, 64'd0);
        chk("sw_exec_b", alu_b, 64'd8);
        alu_result = 64'h1008;
        rdata2     = 64'hBAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_result = '0;
            chk("sw_mem_req", {63'd0, mem_req}, 64'd1);
            chk("sw_mem_we", {63'd0, mem_write_en}, 64'd1);
            chk("sw_mem_addr", mem_addr, 64'h1008);
            chk("sw_mem_wdata", mem_wdata, 64'hCAFE);
            chk("sw_no_wb", {63'd0, reg_write_en}, 64'd0);
            if (i == 3) begin
                mem_ready = 1'b1;
                #1;
                chk("sw_pc_inc", {63'd0, pc_inc}, 64'd1);
            end else begin
                chk("sw_no_pc_inc", {63'd0, pc_inc}, 64'd0);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        chk("sw_back_to_fetch", {63'd0, fetch_req}, 64'd1);
        chk("sw_idle_outputs", {61'd0, mem_req, reg_write_en, pc_inc}, 64'd0);

        // LW x0,4(x1) with mem_ready in the same cycle as mem_req
        fetch(32'h0040A003, 64'h2000, 64'd0);
        @(negedge clk);
        chk("lw_exec_b", alu_b, 64'd4);
        alu_result = 64'h2004;
        @(negedge clk);
        alu_result = '0;
        chk("lw_mem_req", {63'd0, mem_req}, 64'd1);
        chk("lw_mem_we", {63'd0, mem_write_en}, 64'd0);
        chk("lw_mem_addr", mem_addr, 64'h2004);
        mem_ready = 1'b1;
        mem_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("lw_mem_no_pc_inc", {63'd0, pc_inc}, 64'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("lw_x0_no_write", {63'd0, reg_write_en}, 64'd0);
        chk("lw_wb_data", wb_data, 64'h1234_5678_9ABC_DEF0);
        chk("lw_pc_inc", {63'd0, pc_inc}, 64'd1);
        @(negedge clk);

        // Reset while waiting on the divider
        fetch(32'h0220C733, 64'd9, 64'd3);
        @(negedge clk);
        @(negedge clk);
        chk("rst_div_waiting", {59'd0, alu_op}, 64'd12);
        #2 reset = 1'b1;
        #1;
        chk("rst_div_outputs_zero", {63'd0, any_out()}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_div_fetch_req", {63'd0, fetch_req}, 64'd1);
        run_vec(vecs[1]);

        // Illegal opcode 0x7F: sticky trap until reset
        fetch(32'h0000007F, 64'd0, 64'd0);
        @(negedge clk);
        chk("trap_illegal", {63'd0, illegal}, 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("trap_sticky", {63'd0, illegal}, 64'd1);
            chk("trap_no_fetch", {63'd0, fetch_req}, 64'd0);
        end
        reset = 1'b1;
        #1;
        chk("trap_reset_clears", {63'd0, illegal}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("trap_reset_fetch", {63'd0, fetch_req}, 64'd1);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
